// File: rtl/fp_addsub_ci.sv
// fp_addsub_ci -- Nios II custom-instruction wrapper around an external
// pipelined fp_add_sub unit (IEEE-754 single precision).
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous active-high reset
//   clk_en     : custom-instruction clock enable; qualifies start only
//   start      : instruction request (sampled only when clk_en=1)
//   n[1:0]     : opcode 0=add, 1=sub, 2=accumulate, 3=read-and-clear acc
//   dataa      : operand A
//   datab      : operand B
//   done       : one-cycle completion strobe
//   result     : instruction result, held until the next completion
//   fpu_dataa  : registered operand to fp_add_sub.dataa
//   fpu_datab  : registered operand to fp_add_sub.datab
//   fpu_result : fp_add_sub.result
//   dbg_state  : current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Handshake: a request is accepted on a rising edge where the FSM is not
// BUSY and clk_en=1 and start=1. Exactly one done pulse follows each
// accepted request; requests made while BUSY are dropped, not queued.
// The FPU pipeline is free-running, so clk_en never stalls an operation.

module fp_addsub_ci #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] fpu_dataa,
  output logic [31:0] fpu_datab,
  input  logic [31:0] fpu_result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_n;
  logic [31:0] r_acc;
  logic        r_done;
  logic [31:0] r_result;
  logic [31:0] r_fpu_a;
  logic [31:0] r_fpu_b;

  logic        w_accept;
  logic        w_last;

  assign w_accept = (r_state != BUSY) && clk_en && start;
  // Read-and-clear finishes on the first BUSY edge; FPU ops wait until the
  // counter has seen LATENCY+1 edges so the pipeline output is valid.
  assign w_last   = (r_n == 2'd3) || (r_cnt == LAT4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_n      <= 2'd0;
      r_acc    <= 32'd0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_fpu_a  <= 32'd0;
      r_fpu_b  <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_n     <= n;
            r_cnt   <= 4'd0;
            r_state <= BUSY;
            case (n)
              2'd0: begin
                r_fpu_a <= dataa;
                r_fpu_b <= datab;
              end
              2'd1: begin
                // Pure sign flip: NaNs are passed through with flipped sign.
                r_fpu_a <= dataa;
                r_fpu_b <= {~datab[31], datab[30:0]};
              end
              2'd2: begin
                r_fpu_a <= r_acc;
                r_fpu_b <= dataa;
              end
              default: begin
                // Read-and-clear leaves the FPU operands untouched.
              end
            endcase
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
            if (r_n == 2'd3) begin
              r_result <= r_acc;
              r_acc    <= 32'd0;
            end else begin
              r_result <= fpu_result;
              if (r_n == 2'd2) begin
                r_acc <= fpu_result;
              end
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign done      = r_done;
  assign result    = r_result;
  assign fpu_dataa = r_fpu_a;
  assign fpu_datab = r_fpu_b;
  assign dbg_state = r_state;

endmodule
